// File: rtl/semaforo_peatonal.sv
// Pedestrian signal head slaved to the vehicle light's R/A/V lamps.
// Optional request path (pushbutton, synchroniser, SOL) enabled by defining SEM_PEA_REQ_EN.
module semaforo_peatonal #(
  parameter int GUARD_CYC  = 2,
  parameter int GREEN_CYC  = 8,
  parameter int BLINK_CYC  = 4,
  parameter int BLINK_HALF = 1,
  parameter int CW         = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic R,
  input  logic A,
  input  logic V,
  input  logic P,
  output logic PR,
  output logic PV,
  output logic SOL,
  output logic ERR
);

  typedef enum logic [2:0] {
    APAGADO, ROJO, ESPERA, VERDE, PARPADEO, RETENCION, FALLO
  } st_t;

  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] GREEN_LD = CW'(GREEN_CYC - 1);
  localparam logic [CW-1:0] BLINK_LD = CW'(BLINK_CYC - 1);
  localparam logic [CW-1:0] HALF_LD  = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  st_t           st, nst;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] bcnt, bcnt_n;
  logic          bad_q;
  logic          fault, abort, expire, grant;
  logic          pr_n, pv_n, err_n;

  // Fault needs the previous sample invalid as well as the current one.
  assign fault  = EN && !$onehot({R, A, V}) && bad_q;
  assign abort  = (st == ESPERA || st == VERDE || st == PARPADEO) && !R;
  assign expire = (cnt == '0);

  always_comb begin
    nst = st;
    if (!EN) begin
      nst = APAGADO;
    end else if (fault) begin
      nst = FALLO;
    end else if (abort) begin
      nst = ROJO;
    end else begin
      case (st)
        APAGADO:   nst = ROJO;
        ROJO:      if (R && grant) nst = ESPERA;
        ESPERA:    if (expire) nst = VERDE;
        VERDE:     if (expire) nst = PARPADEO;
        PARPADEO:  if (expire) nst = RETENCION;
        RETENCION: if (!R) nst = ROJO;
        FALLO:     nst = FALLO;
        default:   nst = APAGADO;
      endcase
    end
  end

  // Phase counter: loaded with N-1 on entry, saturates at zero.
  always_comb begin
    cnt_n = '0;
    if (nst != st) begin
      case (nst)
        ESPERA:   cnt_n = GUARD_LD;
        VERDE:    cnt_n = GREEN_LD;
        PARPADEO: cnt_n = BLINK_LD;
        default:  cnt_n = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_n = cnt - ONE;
    end
  end

  always_comb begin
    pr_n   = (nst == ROJO) || (nst == ESPERA) || (nst == RETENCION) || (nst == FALLO);
    err_n  = (nst == FALLO);
    pv_n   = 1'b0;
    bcnt_n = '0;
    if (nst == VERDE) begin
      pv_n = 1'b1;
    end else if (nst == PARPADEO) begin
      if (st != PARPADEO) begin
        pv_n   = 1'b1;
        bcnt_n = HALF_LD;
      end else if (bcnt == '0) begin
        pv_n   = ~PV;
        bcnt_n = HALF_LD;
      end else begin
        pv_n   = PV;
        bcnt_n = bcnt - ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st    <= APAGADO;
      cnt   <= '0;
      bcnt  <= '0;
      bad_q <= 1'b0;
      PR    <= 1'b0;
      PV    <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      st    <= nst;
      cnt   <= cnt_n;
      bcnt  <= bcnt_n;
      bad_q <= EN && !$onehot({R, A, V});
      PR    <= pr_n;
      PV    <= pv_n;
      ERR   <= err_n;
    end
  end

`ifdef SEM_PEA_REQ_EN
  logic s1, s2, s3, rise, sol_n;

  assign rise  = s2 && !s3;
  assign grant = SOL;

  always_comb begin
    sol_n = SOL;
    if (nst == APAGADO || nst == FALLO) begin
      sol_n = 1'b0;
    end else if (abort) begin
      sol_n = 1'b1;
    end else if (nst == VERDE && st != VERDE) begin
      sol_n = 1'b0;
    end else if (rise && st != APAGADO && st != FALLO) begin
      sol_n = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      SOL <= 1'b0;
    end else begin
      s1  <= P;
      s2  <= s1;
      s3  <= s2;
      SOL <= sol_n;
    end
  end
`else
  logic unused_p;

  assign unused_p = P;
  assign grant    = 1'b1;
  assign SOL      = 1'b0;
`endif

endmodule

// File: tb/tb_semaforo_peatonal.sv
// Self-checking bench for semaforo_peatonal: vector table, hand sequences,
// and randomized lamp/enable/button traffic against a phase-timing model.
module tb_semaforo_peatonal;

  localparam int GUARD = 2;
  localparam int GREEN = 8;
  localparam int BLINK = 4;
  localparam int HALF  = 1;

  localparam int OFF = 0, RED = 1, WAIT = 2, GRN = 3, BLK = 4, HOLD = 5, FLT = 6;

  logic CLK = 1'b0;
  logic RST, EN, R, A, V, P;
  logic PR, PV, SOL, ERR;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  semaforo_peatonal #(
    .GUARD_CYC(GUARD), .GREEN_CYC(GREEN), .BLINK_CYC(BLINK), .BLINK_HALF(HALF), .CW(8)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .R(R), .A(A), .V(V), .P(P),
    .PR(PR), .PV(PV), .SOL(SOL), .ERR(ERR)
  );

  typedef struct {
    logic       en, r, a, v;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, r, a, v, input logic [3:0] e);
    vec_t t;
    t.en = en; t.r = r; t.a = a; t.v = v; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {PR,PV,SOL,ERR} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: current phase plus cycles elapsed in it.
  int m_ph, m_k;
  bit m_bad, m_sol;
  bit m_p [3];

  task automatic model_reset();
    m_ph = OFF; m_k = 0; m_bad = 0; m_sol = 0;
    for (int i = 0; i < 3; i++) m_p[i] = 0;
  endtask

  function automatic logic [3:0] m_out();
    logic pr, pv;
    pr = (m_ph == RED) || (m_ph == WAIT) || (m_ph == HOLD) || (m_ph == FLT);
    pv = (m_ph == GRN) || (m_ph == BLK && ((m_k / HALF) % 2 == 0));
    return {pr, pv, m_sol, m_ph == FLT};
  endfunction

  task automatic model_step(input bit en, r, a, v, p);
    bit valid, rise, grant, ab;
    int len, nph;
    valid = (int'(r) + int'(a) + int'(v)) == 1;
    rise  = m_p[1] && !m_p[2];
    len   = (m_ph == WAIT) ? GUARD : (m_ph == GRN) ? GREEN : (m_ph == BLK) ? BLINK : 0;
    ab    = (m_ph == WAIT || m_ph == GRN || m_ph == BLK) && !r;
`ifdef SEM_PEA_REQ_EN
    grant = m_sol;
`else
    grant = 1'b1;
`endif
    nph = m_ph;
    if (!en) nph = OFF;
    else if (m_bad && !valid) nph = FLT;
    else if (ab) nph = RED;
    else if (m_ph == OFF) nph = RED;
    else if (m_ph == RED && r && grant) nph = WAIT;
    else if (len != 0 && m_k == len - 1) nph = (m_ph == WAIT) ? GRN : (m_ph == GRN) ? BLK : HOLD;
    else if (m_ph == HOLD && !r) nph = RED;
`ifdef SEM_PEA_REQ_EN
    if (nph == OFF || nph == FLT) m_sol = 0;
    else if (ab) m_sol = 1;
    else if (nph == GRN && m_ph != GRN) m_sol = 0;
    else if (rise && m_ph != OFF && m_ph != FLT) m_sol = 1;
`endif
    m_k   = (nph != m_ph) ? 0 : m_k + 1;
    m_ph  = nph;
    m_bad = en && !valid;
    m_p[2] = m_p[1]; m_p[1] = m_p[0]; m_p[0] = p;
  endtask

  task automatic drive(input bit en, r, a, v, p);
    EN = en; R = r; A = a; V = v; P = p;
  endtask

  task automatic apply(input bit en, r, a, v, p, input logic [3:0] e, input string name);
    drive(en, r, a, v, p);
    @(posedge CLK); #1;
    check(name, {PR, PV, SOL, ERR}, e);
  endtask

  task automatic cyc(input bit en, r, a, v, p);
    drive(en, r, a, v, p);
    model_step(en, r, a, v, p);
    @(posedge CLK); #1;
    check("rand", {PR, PV, SOL, ERR}, m_out());
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1, 0);
    RST = 1'b0;
    model_reset();
    #3;
    check("reset_async", {PR, PV, SOL, ERR}, 4'b0000);
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hold", {PR, PV, SOL, ERR}, 4'b0000);
    RST = 1'b1;
  endtask

  int en_off, seg, lamp, glitch;
  bit pb;

  initial begin
    RST = 1'b0;
    drive(0, 0, 0, 1, 0);
    #2;
    do_reset();
    apply(0, 0, 0, 1, 0, 4'b0000, "off_after_reset");

`ifndef SEM_PEA_REQ_EN
    // Full phase, then lamp fault and its release through EN.
    add(1, 0, 0, 1, 4'b1000);
    add(1, 0, 0, 1, 4'b1000);
    add(1, 1, 0, 0, 4'b1000);
    add(1, 1, 0, 0, 4'b1000);
    add(1, 1, 0, 0, 4'b0100);
    for (int i = 0; i < GREEN - 1; i++) add(1, 1, 0, 0, 4'b0100);
    add(1, 1, 0, 0, 4'b0100);
    add(1, 1, 0, 0, 4'b0000);
    add(1, 1, 0, 0, 4'b0100);
    add(1, 1, 0, 0, 4'b0000);
    add(1, 1, 0, 0, 4'b1000);
    add(1, 1, 0, 0, 4'b1000);
    add(1, 0, 1, 0, 4'b1000);
    add(1, 1, 0, 1, 4'b1000);
    add(1, 1, 0, 1, 4'b1001);
    add(1, 1, 0, 0, 4'b1001);
    add(1, 0, 0, 1, 4'b1001);
    add(0, 0, 0, 1, 4'b0000);
    add(0, 1, 0, 1, 4'b0000);
    add(1, 1, 0, 1, 4'b1000);
    add(0, 0, 0, 1, 4'b0000);
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].en, tbl[i].r, tbl[i].a, tbl[i].v, 1'b0, tbl[i].exp, $sformatf("tbl%0d", i));

    // R dropped during the 4th green cycle.
    apply(1, 0, 0, 1, 0, 4'b1000, "ab_on");
    apply(1, 1, 0, 0, 0, 4'b1000, "ab_esp1");
    apply(1, 1, 0, 0, 0, 4'b1000, "ab_esp2");
    for (int i = 0; i < 4; i++) apply(1, 1, 0, 0, 0, 4'b0100, $sformatf("ab_v%0d", i + 1));
    apply(1, 0, 0, 1, 0, 4'b1000, "ab_abort");
    apply(1, 0, 0, 1, 0, 4'b1000, "ab_rojo");

    // Two 20-cycle red phases with the button toggling.
    for (int ph = 0; ph < 2; ph++) begin
      int greens, sols;
      greens = 0; sols = 0;
      for (int i = 0; i < 20; i++) begin
        drive(1, 1, 0, 0, 1'($urandom_range(0, 1)));
        @(posedge CLK); #1;
        if (!PR && !ERR) greens++;
        if (SOL) sols++;
      end
      check_int($sformatf("phase%0d_green_cycles", ph), greens, GREEN + BLINK);
      check_int($sformatf("phase%0d_sol", ph), sols, 0);
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 5; i++) begin
        @(posedge CLK); #1;
      end
      check($sformatf("phase%0d_end", ph), {PR, PV, SOL, ERR}, 4'b1000);
    end
`else
    // Request-gated phase, then a phase with no request.
    apply(1, 0, 0, 1, 0, 4'b1000, "rq_on");
    apply(1, 0, 0, 1, 1, 4'b1000, "rq_p1");
    apply(1, 0, 0, 1, 1, 4'b1000, "rq_p2");
    apply(1, 0, 0, 1, 0, 4'b1010, "rq_sol");
    apply(1, 1, 0, 0, 0, 4'b1010, "rq_esp1");
    apply(1, 1, 0, 0, 0, 4'b1010, "rq_esp2");
    for (int i = 0; i < GREEN; i++) apply(1, 1, 0, 0, 0, 4'b0100, $sformatf("rq_v%0d", i));
    apply(1, 1, 0, 0, 0, 4'b0100, "rq_b0");
    apply(1, 1, 0, 0, 0, 4'b0000, "rq_b1");
    apply(1, 1, 0, 0, 0, 4'b0100, "rq_b2");
    apply(1, 1, 0, 0, 0, 4'b0000, "rq_b3");
    apply(1, 1, 0, 0, 0, 4'b1000, "rq_hold");
    apply(1, 0, 0, 1, 0, 4'b1000, "rq_rojo");
    for (int i = 0; i < 12; i++) apply(1, 1, 0, 0, 0, 4'b1000, $sformatf("rq_nopress%0d", i));
`endif

    // Randomized traffic against the model.
    do_reset();
    en_off = 0; seg = 0; lamp = 2; glitch = 0; pb = 0;
    for (int n = 0; n < 1500; n++) begin
      bit en, r, a, v;
      logic [2:0] bad;
      if (en_off > 0) en_off--;
      else if ($urandom_range(0, 99) < 2) en_off = $urandom_range(1, 3);
      en = (en_off == 0);
      if (seg == 0) begin
        lamp = (lamp == 0) ? 2 : (lamp == 2) ? 1 : 0;
        seg  = (lamp == 0) ? $urandom_range(3, 25) : (lamp == 2) ? $urandom_range(2, 8) : $urandom_range(1, 3);
      end
      seg--;
      r = (lamp == 0); a = (lamp == 1); v = (lamp == 2);
      if (glitch > 0) begin
        glitch--;
        bad = 3'($urandom_range(0, 3));
        case (bad)
          3'd0:    {r, a, v} = 3'b000;
          3'd1:    {r, a, v} = 3'b101;
          3'd2:    {r, a, v} = 3'b110;
          default: {r, a, v} = 3'b111;
        endcase
      end else if ($urandom_range(0, 99) < 3) begin
        glitch = $urandom_range(1, 2);
      end
      if ($urandom_range(0, 99) < 20) pb = ~pb;
      cyc(en, r, a, v, pb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
